// File: rtl/antares_memory_arbiter_if.sv
// antares_memory_arbiter_if: fetch port, data port and external bus signals of the memory arbiter
interface antares_memory_arbiter_if;
   logic [31:0] imem_address;
   logic        imem_enable;
   logic [31:0] imem_rd_data;
   logic        imem_ready;
   logic        imem_error;
   logic [31:0] dmem_address;
   logic [31:0] dmem_wr_data;
   logic [3:0]  dmem_wr_be;
   logic        dmem_enable;
   logic [31:0] dmem_rd_data;
   logic        dmem_ready;
   logic        dmem_error;
   logic        imem_request_stall;
   logic        dmem_request_stall;
   logic [31:0] bus_address;
   logic [31:0] bus_wr_data;
   logic [3:0]  bus_wr_be;
   logic        bus_enable;
   logic [31:0] bus_rd_data;
   logic        bus_ready;
   modport master (
      output imem_address, imem_enable, dmem_address, dmem_wr_data, dmem_wr_be, dmem_enable,
             bus_rd_data, bus_ready,
      input  imem_rd_data, imem_ready, imem_error, dmem_rd_data, dmem_ready, dmem_error,
             imem_request_stall, dmem_request_stall, bus_address, bus_wr_data, bus_wr_be, bus_enable
   );
   modport slave (
      input  imem_address, imem_enable, dmem_address, dmem_wr_data, dmem_wr_be, dmem_enable,
             bus_rd_data, bus_ready,
      output imem_rd_data, imem_ready, imem_error, dmem_rd_data, dmem_ready, dmem_error,
             imem_request_stall, dmem_request_stall, bus_address, bus_wr_data, bus_wr_be, bus_enable
   );
endinterface

// File: rtl/antares_memory_arbiter.sv
// antares_memory_arbiter: shares one memory bus between fetch and data ports with round-robin ties and a watchdog
module antares_memory_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic clk,
   input logic rst,
   antares_memory_arbiter_if.slave m
);
   typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   state_t     state;
   logic [7:0] wait_cnt;
   logic       last_grant;
   logic       grant_d;
   logic       timeout;
   // last_grant is 1 for the data port; a tie goes to whichever port was not served last
   assign grant_d = m.dmem_enable && (!m.imem_enable || !last_grant);
   assign timeout = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_LIMIT) && !m.bus_ready;
   assign m.imem_request_stall = m.imem_enable & ~m.imem_ready;
   assign m.dmem_request_stall = m.dmem_enable & ~m.dmem_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wait_cnt       <= '0;
         last_grant     <= 1'b1;
         m.bus_address  <= '0;
         m.bus_wr_data  <= '0;
         m.bus_wr_be    <= '0;
         m.bus_enable   <= 1'b0;
         m.imem_rd_data <= '0;
         m.imem_ready   <= 1'b0;
         m.imem_error   <= 1'b0;
         m.dmem_rd_data <= '0;
         m.dmem_ready   <= 1'b0;
         m.dmem_error   <= 1'b0;
      end else begin
         m.imem_ready <= 1'b0;
         m.imem_error <= 1'b0;
         m.dmem_ready <= 1'b0;
         m.dmem_error <= 1'b0;
         case (state)
            IDLE: if (m.dmem_enable || m.imem_enable) begin
               state         <= grant_d ? BUS_D : BUS_I;
               last_grant    <= grant_d;
               m.bus_address <= grant_d ? m.dmem_address : m.imem_address;
               m.bus_wr_data <= grant_d ? m.dmem_wr_data : m.bus_wr_data;
               m.bus_wr_be   <= grant_d ? m.dmem_wr_be : 4'b0000;
               m.bus_enable  <= 1'b1;
               wait_cnt      <= '0;
            end
            BUS_I, BUS_D: if (m.bus_ready || timeout) begin
               state        <= RESP;
               m.bus_enable <= 1'b0;
               if (state == BUS_D) begin
                  m.dmem_rd_data <= m.bus_ready ? m.bus_rd_data : '0;
                  m.dmem_ready   <= 1'b1;
                  m.dmem_error   <= !m.bus_ready;
               end else begin
                  m.imem_rd_data <= m.bus_ready ? m.bus_rd_data : '0;
                  m.imem_ready   <= 1'b1;
                  m.imem_error   <= !m.bus_ready;
               end
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
